// File: rtl/piso_serializer.sv
// Parallel-in serial-out shift register: sends a WIDTH-bit word one bit per clock
// on SOUT, with a registered complement and valid/last-bit framing flags.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] DIN,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  output logic             SOUT,
  output logic             SOUT_BAR,
  output logic             SVALID,
  output logic             DONE
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;

  logic             last_bit;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

  assign last_bit   = (state == SHIFT) && (cnt == CNT_W'(WIDTH - 1));
  assign LOAD_READY = (state == IDLE) || last_bit;
  assign accept     = LOAD_VALID && LOAD_READY;

  // The first bit goes straight to SOUT at the accepting edge, so the shift
  // register only ever holds the bits still to be sent, moved toward the output end.
  assign first_bit  = MSB_FIRST ? DIN[WIDTH-1]   : DIN[0];
  assign next_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign load_rest  = MSB_FIRST ? {DIN[WIDTH-2:0], 1'b0}   : {1'b0, DIN[WIDTH-1:1]};
  assign shift_rest = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      SOUT     <= 1'b0;
      SOUT_BAR <= 1'b1;
      SVALID   <= 1'b0;
      DONE     <= 1'b0;
    end else if (accept) begin
      state    <= SHIFT;
      shreg    <= load_rest;
      cnt      <= '0;
      SOUT     <= first_bit;
      SOUT_BAR <= ~first_bit;
      SVALID   <= 1'b1;
      DONE     <= 1'b0;
    end else if (state == SHIFT && !last_bit) begin
      shreg    <= shift_rest;
      cnt      <= cnt + 1'b1;
      SOUT     <= next_bit;
      SOUT_BAR <= ~next_bit;
      // DONE is registered, so it rises together with the bit at index WIDTH-1.
      DONE     <= (cnt == CNT_W'(WIDTH - 2));
    end else if (state == SHIFT) begin
      // Last bit sent with no follow-on word: SOUT/SOUT_BAR keep their value.
      state  <= IDLE;
      cnt    <= '0;
      SVALID <= 1'b0;
      DONE   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one MSB-first and one LSB-first instance,
// with expected serial bits queued at stimulus time and popped per output cycle.
module tb_piso_serializer;

  localparam int W = 8;
  localparam int M = 0;  // MSB-first instance
  localparam int L = 1;  // LSB-first instance

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din [2];
  logic         lv  [2];
  logic [1:0]   ready, sout, sout_bar, svalid, done;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST_N(rst_n), .DIN(din[M]), .LOAD_VALID(lv[M]),
    .LOAD_READY(ready[M]), .SOUT(sout[M]), .SOUT_BAR(sout_bar[M]),
    .SVALID(svalid[M]), .DONE(done[M])
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .CLK(clk), .RST_N(rst_n), .DIN(din[L]), .LOAD_VALID(lv[L]),
    .LOAD_READY(ready[L]), .SOUT(sout[L]), .SOUT_BAR(sout_bar[L]),
    .SVALID(svalid[L]), .DONE(done[L])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] d, input bit msb);
    exp_t e;
    for (int i = 0; i < W; i++) begin
      e.b    = msb ? d[W-1-i] : d[i];
      e.last = (i == W - 1);
      sb.push_back(e);
    end
  endtask

  // Checks n output cycles, the first at the current negedge.
  task automatic check_stream(input int sel, input int n);
    exp_t e;
    logic nb;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL sb_underflow observed=empty expected=entry");
      end else begin
        e  = sb.pop_front();
        nb = ~e.b;
        check("svalid",   svalid[sel],   1);
        check("sout",     sout[sel],     e.b);
        check("sout_bar", sout_bar[sel], nb);
        check("done",     done[sel],     e.last);
        check("ready",    ready[sel],    e.last);
      end
    end
  endtask

  task automatic idle_check(input int sel, input logic last_sout);
    logic nb;
    nb = ~last_sout;
    check("idle_svalid",   svalid[sel],   0);
    check("idle_done",     done[sel],     0);
    check("idle_ready",    ready[sel],    1);
    check("idle_sout",     sout[sel],     last_sout);
    check("idle_sout_bar", sout_bar[sel], nb);
  endtask

  task automatic reset_check(input int sel);
    check("rst_sout",     sout[sel],     0);
    check("rst_sout_bar", sout_bar[sel], 1);
    check("rst_svalid",   svalid[sel],   0);
    check("rst_done",     done[sel],     0);
    check("rst_ready",    ready[sel],    1);
  endtask

  initial begin
    din[M] = '0; din[L] = '0;
    lv[M]  = 1'b0; lv[L] = 1'b0;

    // Reset with the clock running.
    repeat (3) @(negedge clk);
    reset_check(M);
    reset_check(L);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(M, 1'b0);

    // Single word, MSB first.
    din[M] = 8'hA5; lv[M] = 1'b1; push_word(8'hA5, 1'b1);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, W);
    @(negedge clk);
    idle_check(M, 1'b1);

    // Single word, LSB first.
    din[L] = 8'h01; lv[L] = 1'b1; push_word(8'h01, 1'b0);
    @(negedge clk); lv[L] = 1'b0;
    check_stream(L, W);
    @(negedge clk);
    idle_check(L, 1'b0);

    // Back-to-back with LOAD_VALID held high across the word boundary.
    din[M] = 8'hFF; lv[M] = 1'b1; push_word(8'hFF, 1'b1);
    @(negedge clk);
    din[M] = 8'h00; push_word(8'h00, 1'b1);
    check_stream(M, W);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, W);
    @(negedge clk);
    idle_check(M, 1'b0);

    // Load request mid-word must be ignored.
    din[M] = 8'hC3; lv[M] = 1'b1; push_word(8'hC3, 1'b1);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, 3);
    @(negedge clk);
    din[M] = 8'h3C; lv[M] = 1'b1;
    check_stream(M, 1);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, 4);
    @(negedge clk);
    idle_check(M, 1'b1);
    @(negedge clk);
    idle_check(M, 1'b1);

    // Reset asserted while bit 4 of 8'hF0 is on SOUT.
    din[M] = 8'hF0; lv[M] = 1'b1; push_word(8'hF0, 1'b1);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, 4);
    @(negedge clk);
    check_stream(M, 1);
    #1 rst_n = 1'b0;
    #1 reset_check(M);
    sb.delete();
    @(negedge clk);
    reset_check(M);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_check(M, 1'b0);

    // Recovery word after reset.
    din[M] = 8'h81; lv[M] = 1'b1; push_word(8'h81, 1'b1);
    @(negedge clk); lv[M] = 1'b0;
    check_stream(M, W);
    @(negedge clk);
    idle_check(M, 1'b1);
    idle_check(L, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in serial-out shift register that converts a WIDTH-bit word into a one-bit-per-clock serial stream, with a complemented output and framing flags.
- Acts as the transmit end of the single-bit D-flip-flop data path: it is the stimulus source that drives serial D-type inputs, and it pairs with a serial-in parallel-out capture chain on the far side.
- Sits between the parallel producer logic and any downstream flip-flop or SIPO chain.

Parameters:
- WIDTH, 8, word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 sends bit WIDTH-1 first; 0 sends bit 0 first.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset; assertion is immediate, release is synchronous to CLK by the system.
- DIN  input  WIDTH  parallel word to transmit.
- LOAD_VALID  input  1  producer has a valid word on DIN.
- LOAD_READY  output  1  block accepts a word this cycle.
- SOUT  output  1  serial data bit (registered).
- SOUT_BAR  output  1  always the complement of SOUT (registered).
- SVALID  output  1  SOUT carries a valid frame bit this cycle.
- DONE  output  1  one-cycle pulse, high while the last bit of a word is on SOUT.

Behaviour:
- Reset values (RST_N=0, asynchronous):
  - State IDLE, shift register 0, bit counter 0.
  - SOUT=0, SOUT_BAR=1, SVALID=0, DONE=0, LOAD_READY=1.
- Handshake:
  - A word is accepted on a rising edge where LOAD_VALID=1 and LOAD_READY=1; DIN is sampled at that edge.
  - LOAD_READY is combinational from state. It is 1 in IDLE and 1 during the last-bit cycle of SHIFT; otherwise it is 0.
  - When LOAD_READY=0, LOAD_VALID is ignored and DIN may change freely.
- State machine:
  - IDLE: SVALID=0, SOUT holds its last value, SOUT_BAR=~SOUT. On accept, go to SHIFT with counter=0.
  - SHIFT: SVALID=1; SOUT shows bit[counter], counted from MSB or LSB per MSB_FIRST; counter increments each cycle.
    - When counter==WIDTH-1, DONE=1 for that cycle.
    - Next edge: with a new accept, stay in SHIFT, reload, counter=0; otherwise go to IDLE.
- Latency and throughput:
  - The first bit appears on SOUT in the cycle after the accepting edge, i.e. registered with no combinational DIN->SOUT path.
  - A word occupies exactly WIDTH consecutive cycles of SVALID=1.
  - Back-to-back words stream gap-free: WIDTH*N cycles for N words.
- Width rules:
  - Counter width is $clog2(WIDTH).
  - Shift register is WIDTH bits and shifts toward the output end; the vacated bit fills with 0.
- Boundary conditions:
  - LOAD_VALID held high continuously gives a continuous stream, with a new word accepted every WIDTH cycles.
  - LOAD_VALID asserted mid-word while LOAD_READY=0 is not accepted and does not disturb the current word.
  - RST_N asserted mid-word aborts the word immediately: outputs take reset values in the same instant and no DONE is issued. After release the block is in IDLE.
  - DONE never asserts in IDLE. SVALID and DONE are never high without SHIFT.
  - SOUT_BAR is never equal to SOUT in any cycle, including during reset.

Test Plan:
- Reset check:
  - Stimulus: RST_N=0 while CLK runs with a 10 ns period.
  - Required: SOUT=0, SOUT_BAR=1, SVALID=0, DONE=0, LOAD_READY=1.
- Single word, MSB first:
  - Stimulus: WIDTH=8, MSB_FIRST=1, DIN=8'hA5, LOAD_VALID for 1 cycle.
  - Required: SOUT sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles with SVALID=1; DONE high only on the 8th bit; then IDLE with SVALID=0.
- LSB first:
  - Stimulus: MSB_FIRST=0, DIN=8'h01.
  - Required: SOUT sequence 1,0,0,0,0,0,0,0; SOUT_BAR is the inverse on every cycle.
- Back-to-back:
  - Stimulus: LOAD_VALID held at 1 with DIN=8'hFF then 8'h00.
  - Required: 16 contiguous SVALID cycles, SOUT eight 1s then eight 0s, DONE pulses on cycles 8 and 16, no gap cycle.
- Ignored load:
  - Stimulus: send 8'hC3, then pulse LOAD_VALID with DIN=8'h3C on bit 3.
  - Required: stream remains 1,1,0,0,0,0,1,1 and the block returns to IDLE after it.
- Reset mid-word:
  - Stimulus: drop RST_N during bit 4 of 8'hF0.
  - Required: SVALID=0 and SOUT=0 immediately, no DONE. After release, a new 8'h81 transmits correctly as 1,0,0,0,0,0,0,1.
